// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolver partial-sum collector.
package conv_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} psum_state_e;

  localparam int GuardBitsDefault = 4;

  // Width of the intermediate arithmetic used for accumulation and requantization.
  localparam int SatW = 64;

  // Clamp v into the signed range of a w-bit value, returned sign-extended to SatW.
  function automatic logic signed [SatW-1:0] sat_signed(input logic signed [SatW-1:0] v,
                                                        input int unsigned w);
    logic signed [SatW-1:0] hi;
    logic signed [SatW-1:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/psum_ram.sv
// Simple dual-port partial-sum RAM: one write port, one synchronous read port.
module psum_ram #(
  parameter int Depth = 676,
  parameter int Width = 36,
  parameter int AddrW = 10
) (
  input  logic             clk_i,
  input  logic             wr_en,
  input  logic [AddrW-1:0] wr_addr,
  input  logic [Width-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AddrW-1:0] rd_addr,
  output logic [Width-1:0] rd_data
);

  logic [Width-1:0] mem [Depth];

  // Write port: partial sums from the write/emit stage.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read port: data appears the cycle after the accept stage issues the address.
  always_ff @(posedge clk_i) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/conv_psum_collector.sv
// Collects convolver results, accumulates partial sums across input channels and,
// on the last channel, adds bias, requantizes, applies optional ReLU and saturates.
module conv_psum_collector
  import conv_pkg::*;
#(
  parameter int N          = 16,
  parameter int MaxOutSize = 26,
  parameter int GuardBits  = GuardBitsDefault
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic                  first_channel_i,
  input  logic                  last_channel_i,
  input  logic [13:0]           out_size_i,
  input  logic signed [2*N-1:0] bias_i,
  input  logic [5:0]            shift_i,
  input  logic                  relu_en_i,
  input  logic signed [2*N-1:0] conv_i,
  input  logic                  valid_conv_i,
  input  logic                  end_conv_i,
  output logic signed [N-1:0]   data_o,
  output logic                  data_valid_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  overflow_o,
  output logic                  count_err_o,
  input  logic                  assert_on_i
);

  localparam int AccW  = 2*N + GuardBits;
  localparam int Depth = MaxOutSize*MaxOutSize;
  localparam int AddrW = $clog2(Depth);
  localparam int CntW  = 28;
  localparam int VW    = SatW;

  // Round-half-up arithmetic right shift used for requantization.
  function automatic logic signed [VW-1:0] round_shift(input logic signed [VW-1:0] v,
                                                       input logic [5:0] sh);
    logic signed [VW-1:0] r;
    r = v;
    if (sh != 6'd0) r = (v + (64'sd1 <<< (sh - 6'd1))) >>> sh;
    return r;
  endfunction

  // Clamp negatives to zero when enabled.
  function automatic logic signed [VW-1:0] relu(input logic signed [VW-1:0] v, input logic en);
    logic signed [VW-1:0] r;
    r = v;
    if (en && v < 0) r = '0;
    return r;
  endfunction

  psum_state_e state_q, state_d;

  logic [CntW-1:0]       cnt_q;
  logic [CntW-1:0]       total_q;
  logic                  first_q;
  logic                  last_q;
  logic                  relu_q;
  logic signed [2*N-1:0] bias_q;
  logic [5:0]            shift_q;

  logic                  vld_p0;
  logic                  vld_p1;
  logic signed [2*N-1:0] conv_p0;
  logic [AddrW-1:0]      addr_p0;
  logic [AddrW-1:0]      addr_p1;
  logic signed [AccW-1:0] sum_p1;
  logic signed [AccW-1:0] psum_rd;

  logic start_ok;
  logic accept;
  logic last_beat;

  logic signed [VW-1:0] s2_v;
  logic signed [VW-1:0] s2_sat;
  logic                 s2_ovf;
  logic signed [VW-1:0] s3_v;
  logic signed [VW-1:0] s3_sat;
  logic                 s3_ovf;

  assign start_ok  = (state_q == IDLE) && start_i;
  assign accept    = (state_q == ACCUM) && valid_conv_i && (cnt_q < total_q);
  assign last_beat = accept && ((cnt_q + CntW'(1)) == total_q);

  assign busy_o = (state_q == ACCUM) || (state_q == DRAIN);
  assign done_o = (state_q == DONE);

  // Next-state logic: a pass runs IDLE -> ACCUM -> DRAIN -> DONE -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = ACCUM;
      ACCUM:   if ((cnt_q == total_q) || end_conv_i) state_d = DRAIN;
      DRAIN:   if (!vld_p0 && !vld_p1) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control state: FSM, beat counter, pipe valids, outputs and sticky flags.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      vld_p0       <= 1'b0;
      vld_p1       <= 1'b0;
      data_valid_o <= 1'b0;
      data_o       <= '0;
      overflow_o   <= 1'b0;
      count_err_o  <= 1'b0;
    end else begin
      state_q      <= state_d;
      vld_p0       <= accept;
      vld_p1       <= vld_p0;
      data_valid_o <= vld_p1 && last_q;
      if (vld_p1 && last_q) data_o <= s3_sat[N-1:0];

      if (start_ok)    cnt_q <= '0;
      else if (accept) cnt_q <= cnt_q + CntW'(1);

      if (start_ok)
        overflow_o <= 1'b0;
      else if ((vld_p0 && s2_ovf) || (vld_p1 && last_q && s3_ovf))
        overflow_o <= 1'b1;

      if (start_ok)
        count_err_o <= 1'b0;
      else if ((state_q == ACCUM) &&
               ((valid_conv_i && (cnt_q == total_q)) ||
                (end_conv_i && (cnt_q != total_q) && !last_beat)))
        count_err_o <= 1'b1;
    end
  end

  // Pass configuration, captured once per start.
  always_ff @(posedge clk_i) begin
    if (start_ok) begin
      first_q <= first_channel_i;
      last_q  <= last_channel_i;
      relu_q  <= relu_en_i;
      bias_q  <= bias_i;
      shift_q <= shift_i;
      total_q <= CntW'(out_size_i) * CntW'(out_size_i);
    end
  end

  // S1 -> p0: register accepted beat and its psum address.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      conv_p0 <= conv_i;
      addr_p0 <= cnt_q[AddrW-1:0];
    end
  end

  // S2: accumulate onto the stored partial sum (or start fresh on the first channel).
  always_comb begin
    s2_v   = first_q ? VW'(conv_p0) : (VW'(psum_rd) + VW'(conv_p0));
    s2_sat = sat_signed(s2_v, AccW);
    s2_ovf = (s2_sat != s2_v);
  end

  // S2 -> p1: register the saturated sum for write-back or emission.
  always_ff @(posedge clk_i) begin
    if (vld_p0) begin
      sum_p1  <= s2_sat[AccW-1:0];
      addr_p1 <= addr_p0;
    end
  end

  // S3: bias, round/shift, ReLU, saturate to the output width.
  always_comb begin
    s3_v   = relu(round_shift(VW'(sum_p1) + VW'(bias_q), shift_q), relu_q);
    s3_sat = sat_signed(s3_v, N);
    s3_ovf = (s3_sat != s3_v);
  end

  psum_ram #(
    .Depth (Depth),
    .Width (AccW),
    .AddrW (AddrW)
  ) u_psum_ram (
    .clk_i   (clk_i),
    .wr_en   (vld_p1 && !last_q),
    .wr_addr (addr_p1),
    .wr_data (sum_p1),
    .rd_en   (accept),
    .rd_addr (cnt_q[AddrW-1:0]),
    .rd_data (psum_rd)
  );

  a_out_size_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (assert_on_i && start_ok) |-> (out_size_i <= 14'(MaxOutSize)));

endmodule

// File: tb/tb_conv_psum_collector.sv
// Directed, table-driven bench for conv_psum_collector (N=8).
module tb_conv_psum_collector;

  localparam int N = 8;

  logic                  clk_i = 1'b0;
  logic                  rst_ni;
  logic                  start_i;
  logic                  first_channel_i;
  logic                  last_channel_i;
  logic [13:0]           out_size_i;
  logic signed [2*N-1:0] bias_i;
  logic [5:0]            shift_i;
  logic                  relu_en_i;
  logic signed [2*N-1:0] conv_i;
  logic                  valid_conv_i;
  logic                  end_conv_i;
  logic signed [N-1:0]   data_o;
  logic                  data_valid_o;
  logic                  busy_o;
  logic                  done_o;
  logic                  overflow_o;
  logic                  count_err_o;
  logic                  assert_on_i;

  conv_psum_collector #(.N(N), .MaxOutSize(26)) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .start_i         (start_i),
    .first_channel_i (first_channel_i),
    .last_channel_i  (last_channel_i),
    .out_size_i      (out_size_i),
    .bias_i          (bias_i),
    .shift_i         (shift_i),
    .relu_en_i       (relu_en_i),
    .conv_i          (conv_i),
    .valid_conv_i    (valid_conv_i),
    .end_conv_i      (end_conv_i),
    .data_o          (data_o),
    .data_valid_o    (data_valid_o),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .overflow_o      (overflow_o),
    .count_err_o     (count_err_o),
    .assert_on_i     (assert_on_i)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Output monitor, sampled on the falling edge.
  logic signed [N-1:0] mon_data [256];
  int mon_cyc [256];
  int mon_n = 0;
  int done_n = 0;
  int done_cyc = 0;
  always @(negedge clk_i) begin
    if (data_valid_o && mon_n < 256) begin
      mon_data[mon_n] = data_o;
      mon_cyc[mon_n]  = cyc;
      mon_n++;
    end
    if (done_o) begin
      done_n++;
      done_cyc = cyc;
    end
  end

  typedef struct packed {
    logic            first;
    logic            last;
    logic            relu;
    logic [15:0]     bias;
    logic [5:0]      shift;
    logic [3:0][15:0] conv;
    logic [3:0][7:0] exp;
    logic            exp_ovf;
  } vec_t;

  function automatic vec_t mkvec(input logic f, input logic l, input logic r,
                                 input int b, input int sh,
                                 input int c0, input int c1, input int c2, input int c3,
                                 input int e0, input int e1, input int e2, input int e3,
                                 input logic ovf);
    vec_t v;
    v.first = f; v.last = l; v.relu = r;
    v.bias = 16'(b); v.shift = 6'(sh);
    v.conv[0] = 16'(c0); v.conv[1] = 16'(c1); v.conv[2] = 16'(c2); v.conv[3] = 16'(c3);
    v.exp[0] = 8'(e0); v.exp[1] = 8'(e1); v.exp[2] = 8'(e2); v.exp[3] = 8'(e3);
    v.exp_ovf = ovf;
    return v;
  endfunction

  int n_chk = 0;
  int n_fail = 0;
  int beat_cyc [16];
  int nb = 0;
  int start_cyc = 0;
  int base_out = 0;
  int base_done = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic st, input logic vld, input int c, input logic endc);
    step();
    start_i      = st;
    valid_conv_i = vld;
    conv_i       = 16'(c);
    end_conv_i   = endc;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic start_pass(input logic f, input logic l, input int sz, input int b,
                            input int sh, input logic r, input logic vld_in_start);
    step();
    first_channel_i = f;
    last_channel_i  = l;
    out_size_i      = 14'(sz);
    bias_i          = 16'(b);
    shift_i         = 6'(sh);
    relu_en_i       = r;
    start_i         = 1'b1;
    valid_conv_i    = vld_in_start;
    conv_i          = 16'sd99;
    end_conv_i      = 1'b0;
    start_cyc = cyc;
    base_out  = mon_n;
    base_done = done_n;
    nb = 0;
  endtask

  task automatic beat(input int c);
    drive(1'b0, 1'b1, c, 1'b0);
    beat_cyc[nb] = cyc;
    nb++;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40 && done_n == base_done; i++) idle(1);
    idle(1);
  endtask

  // Check emitted data, its 3-cycle latency, and the single done pulse after the last beat.
  task automatic check_pass(input string nm, input int n_exp, input logic [3:0][7:0] exp);
    chk($sformatf("%s out_count", nm), mon_n - base_out, n_exp);
    for (int i = 0; i < n_exp; i++) begin
      if (base_out + i < mon_n) begin
        chk($sformatf("%s data[%0d]", nm, i), mon_data[base_out + i], $signed(exp[i]));
        chk($sformatf("%s latency[%0d]", nm, i), mon_cyc[base_out + i] - beat_cyc[i], 3);
      end
    end
    chk($sformatf("%s done_count", nm), done_n - base_done, 1);
    chk($sformatf("%s done_cycle", nm), done_cyc, beat_cyc[nb - 1] + 4);
    chk($sformatf("%s busy_after", nm), busy_o, 0);
  endtask

  vec_t vecs [7];

  initial begin
    vec_t v;
    logic [3:0][7:0] e;

    vecs[0] = mkvec(1, 1, 0,  0, 0,  1,   2,    3,   4,    1,   2,    3,   4,    0);
    vecs[1] = mkvec(1, 0, 0,  0, 0,  10,  10,   10,  10,   0,   0,    0,   0,    0);
    vecs[2] = mkvec(0, 1, 0,  1, 2,  5,   5,    5,   5,    4,   4,    4,   4,    0);
    vecs[3] = mkvec(1, 1, 1,  0, 0, -50, -1,    7,   0,    0,   0,    7,   0,    0);
    vecs[4] = mkvec(1, 1, 0,  0, 0,  300, -300, 127, -128, 127, -128, 127, -128, 1);
    vecs[5] = mkvec(1, 1, 0, -3, 1,  10,  11,  -10,  0,    4,   4,   -6,  -1,    0);
    vecs[6] = mkvec(1, 1, 0,  0, 4,  100, 8,    7,  -8,    6,   1,    0,   0,    0);

    rst_ni = 1'b0; start_i = 1'b0; first_channel_i = 1'b0; last_channel_i = 1'b0;
    out_size_i = '0; bias_i = '0; shift_i = '0; relu_en_i = 1'b0;
    conv_i = '0; valid_conv_i = 1'b0; end_conv_i = 1'b0; assert_on_i = 1'b1;

    repeat (3) step();
    chk("reset data_o", data_o, 0);
    chk("reset data_valid_o", data_valid_o, 0);
    chk("reset busy_o", busy_o, 0);
    chk("reset done_o", done_o, 0);
    chk("reset overflow_o", overflow_o, 0);
    chk("reset count_err_o", count_err_o, 0);
    rst_ni = 1'b1;
    idle(2);

    for (int k = 0; k < 7; k++) begin
      v = vecs[k];
      start_pass(v.first, v.last, 2, $signed(v.bias), int'(v.shift), v.relu, 1'b0);
      for (int i = 0; i < 4; i++) begin
        beat($signed(v.conv[i]));
        if (i == 0) chk($sformatf("vec%0d busy", k), busy_o, 1);
      end
      idle(1);
      wait_done();
      check_pass($sformatf("vec%0d", k), v.last ? 4 : 0, v.exp);
      chk($sformatf("vec%0d overflow", k), overflow_o, v.exp_ovf);
      chk($sformatf("vec%0d count_err", k), count_err_o, 0);
      idle(1);
    end

    // Five valids for four outputs: extra beat dropped, count error flagged.
    e[0] = 8'd1; e[1] = 8'd2; e[2] = 8'd3; e[3] = 8'd4;
    start_pass(1, 1, 2, 0, 0, 0, 1'b0);
    for (int i = 1; i <= 4; i++) beat(i);
    drive(1'b0, 1'b1, 5, 1'b0);
    idle(1);
    wait_done();
    check_pass("extra_valid", 4, e);
    chk("extra_valid count_err", count_err_o, 1);
    chk("extra_valid overflow", overflow_o, 0);
    idle(1);

    // Early end_conv after three beats.
    e[0] = 8'd7; e[1] = 8'd8; e[2] = 8'd9; e[3] = 8'd0;
    start_pass(1, 1, 2, 0, 0, 0, 1'b0);
    beat(7); beat(8); beat(9);
    drive(1'b0, 1'b0, 0, 1'b1);
    idle(1);
    wait_done();
    check_pass("early_end", 3, e);
    chk("early_end count_err", count_err_o, 1);
    idle(1);

    // Beat in the start cycle dropped, gapped valids, and a stray start during ACCUM.
    e[0] = 8'd5; e[1] = 8'd6; e[2] = 8'd7; e[3] = 8'd8;
    start_pass(1, 1, 2, 0, 0, 0, 1'b1);
    beat(5);
    chk("gapped count_err cleared", count_err_o, 0);
    idle(2);
    beat(6);
    out_size_i = 14'd0;
    drive(1'b1, 1'b0, 0, 1'b0);
    idle(1);
    beat(7);
    idle(2);
    beat(8);
    idle(1);
    wait_done();
    check_pass("gapped", 4, e);
    chk("gapped count_err", count_err_o, 0);
    idle(1);

    // Reset in the middle of ACCUM aborts the pass silently.
    start_pass(1, 1, 2, 0, 0, 0, 1'b0);
    beat(1); beat(2);
    step();
    valid_conv_i = 1'b0;
    rst_ni = 1'b0;
    step();
    rst_ni = 1'b1;
    chk("midreset data_o", data_o, 0);
    chk("midreset data_valid_o", data_valid_o, 0);
    chk("midreset busy_o", busy_o, 0);
    idle(8);
    chk("midreset no outputs", mon_n - base_out, 0);
    chk("midreset no done", done_n - base_done, 0);

    e[0] = 8'd3; e[1] = 8'd4; e[2] = 8'd5; e[3] = 8'd6;
    start_pass(1, 1, 2, 0, 0, 0, 1'b0);
    for (int i = 3; i <= 6; i++) beat(i);
    idle(1);
    wait_done();
    check_pass("after_reset", 4, e);
    idle(1);

    // Empty map: straight through to DONE.
    start_pass(1, 1, 0, 0, 0, 0, 1'b0);
    idle(1);
    wait_done();
    chk("size0 out_count", mon_n - base_out, 0);
    chk("size0 done_count", done_n - base_done, 1);
    chk("size0 done_cycle", done_cyc, start_cyc + 3);
    chk("size0 count_err", count_err_o, 0);

    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
